// File: rtl/bus_protocol_if.sv
`default_nettype none
// ============================================================================
//  Module   : bus_protocol_if
//  Purpose  : Simple memory-mapped slave bus. The peripheral_vital modport
//             is the slave view; master is the initiator view.
//  Revision : 1.0 - initial release
// ============================================================================
interface bus_protocol_if;
  logic        wen;
  logic        ren;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  strobe;
  logic [31:0] rdata;
  logic        error;
  logic        request_stall;

  modport peripheral_vital (
    input  wen, ren, addr, wdata, strobe,
    output rdata, error, request_stall
  );

  modport master (
    output wen, ren, addr, wdata, strobe,
    input  rdata, error, request_stall
  );
endinterface
`default_nettype wire

// File: rtl/uart_fifo_periph.sv
`default_nettype none
// ============================================================================
//  Module   : uart_fifo_periph
//  Purpose  : Memory-mapped UART with TX/RX FIFOs, programmable baud divisor
//             and optional RTS/CTS flow control.
//  Options  : UART_PARITY_EN - adds a parity bit after the data bits in both
//             directions (parity = ^data ^ CTRL.odd_parity).
//  Revision : 1.0 - initial release
// ============================================================================
module uart_fifo_periph #(
  parameter int DATA_BITS   = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 867
) (
  input  logic                    clk,
  input  logic                    nReset,
  input  logic                    rx,
  output logic                    tx,
  input  logic                    cts,
  output logic                    rts,
  bus_protocol_if.peripheral_vital bp
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
`ifdef UART_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  // ---------------------------------------------------------------- states
`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {
    TX_IDLE = 3'd0, TX_START = 3'd1, TX_DATA = 3'd2, TX_PARITY = 3'd3, TX_STOP = 3'd4
  } tx_state_e;
  typedef enum logic [2:0] {
    RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2, RX_PARITY = 3'd3, RX_STOP = 3'd4
  } rx_state_e;
`else
  typedef enum logic [2:0] {
    TX_IDLE = 3'd0, TX_START = 3'd1, TX_DATA = 3'd2, TX_STOP = 3'd4
  } tx_state_e;
  typedef enum logic [2:0] {
    RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2, RX_STOP = 3'd4
  } rx_state_e;
`endif

  // ------------------------------------------------------------- registers
  logic [DIV_W-1:0] div_q;
  logic [3:0]       ctrl_q;      // b0 tx_en, b1 rx_en, b2 fc_en, b3 odd_parity
  logic             ovr_q, ferr_q, perr_q;
  logic             rts_q;

  // Bus decode
  logic sel_data, sel_stat, sel_div, sel_ctrl, sel_ok;
  logic stat_rd;
  logic [31:0] rdata;
  logic        err;

  // FIFOs
  logic [DATA_BITS-1:0] txf_mem [FIFO_DEPTH];
  logic [DATA_BITS-1:0] rxf_mem [FIFO_DEPTH];
  logic [AW-1:0]        txf_wp_q, txf_rp_q, rxf_wp_q, rxf_rp_q;
  logic [CW-1:0]        txf_cnt_q, rxf_cnt_q;
  logic                 tx_full, tx_empty, rx_full, rx_empty;
  logic                 tx_push, tx_pop, rx_push, rx_pop;
  logic [DATA_BITS-1:0] tx_head, rx_head;

  // TX FSM
  tx_state_e            tx_state_q, tx_state_d;
  logic [DIV_W-1:0]     tx_tmr_q, tx_tmr_d, tx_lat_q, tx_lat_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic                 tx_q, tx_d;
  logic                 tx_go, tx_load, tx_bit_end;
`ifdef UART_PARITY_EN
  logic                 tx_par_q, tx_par_d;
`endif

  // RX FSM
  rx_state_e            rx_state_q, rx_state_d;
  logic [DIV_W-1:0]     rx_tmr_q, rx_tmr_d, rx_lat_q, rx_lat_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic                 rx_s1_q, rx_s2_q, rx_s3_q;
  logic                 rx_fall, rx_bit_end, rx_mid;
  logic                 rx_push_req, ferr_set, perr_set, ovr_set;

  // Byte strobes are ignored; writes always use the full word.
  logic unused_bits;
  assign unused_bits = ^{bp.strobe, bp.wdata};

  assign sel_data = (bp.addr == 32'h0);
  assign sel_stat = (bp.addr == 32'h4);
  assign sel_div  = (bp.addr == 32'h8);
  assign sel_ctrl = (bp.addr == 32'hC);
  assign sel_ok   = sel_data | sel_stat | sel_div | sel_ctrl;
  assign stat_rd  = bp.ren & sel_stat;

  assign tx_full  = (txf_cnt_q == CW'(FIFO_DEPTH));
  assign tx_empty = (txf_cnt_q == '0);
  assign rx_full  = (rxf_cnt_q == CW'(FIFO_DEPTH));
  assign rx_empty = (rxf_cnt_q == '0);
  assign tx_head  = txf_mem[txf_rp_q];
  assign rx_head  = rxf_mem[rxf_rp_q];

  // A full FIFO still accepts a push when a pop happens on the same edge.
  assign tx_push = bp.wen & sel_data & (~tx_full | tx_pop);
  assign rx_pop  = bp.ren & sel_data & ~rx_empty;
  assign rx_push = rx_push_req & (~rx_full | rx_pop);
  assign ovr_set = rx_push_req & rx_full & ~rx_pop;

  // Read mux and error flag, purely combinational from the current request
  always_comb begin
    rdata = '0;
    err   = 1'b0;
    if ((bp.wen | bp.ren) & ~sel_ok) err = 1'b1;
    if (bp.wen & sel_data & tx_full & ~tx_pop) err = 1'b1;
    if (bp.ren & sel_data & rx_empty) err = 1'b1;
    if (bp.ren) begin
      if (sel_data && !rx_empty) rdata = 32'(rx_head);
      else if (sel_stat) rdata = {25'd0, perr_q, ferr_q, ovr_q,
                                  rx_empty, rx_full, tx_empty, tx_full};
      else if (sel_div)  rdata = 32'(div_q);
      else if (sel_ctrl) rdata = {28'd0, ctrl_q};
    end
  end

  assign bp.rdata         = rdata;
  assign bp.error         = err;
  assign bp.request_stall = 1'b0;

  // Configuration registers (DIV, CTRL)
  always_ff @(posedge clk) begin
    if (!nReset) begin
      div_q  <= DIV_W'(DEFAULT_DIV);
      ctrl_q <= '0;
    end else if (bp.wen) begin
      if (sel_div)  div_q  <= bp.wdata[DIV_W-1:0];
      if (sel_ctrl) ctrl_q <= {PAR_EN & bp.wdata[3], bp.wdata[2:0]};
    end
  end

  // Sticky status flags: STAT read clears, a set on the same edge wins
  always_ff @(posedge clk) begin
    if (!nReset) begin
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      ovr_q  <= ovr_set  | (ovr_q  & ~stat_rd);
      ferr_q <= ferr_set | (ferr_q & ~stat_rd);
      perr_q <= perr_set | (perr_q & ~stat_rd);
    end
  end

  // RTS: advertise RX space only under flow control, low while in reset
  always_ff @(posedge clk) begin
    if (!nReset) rts_q <= 1'b0;
    else         rts_q <= ctrl_q[2] ? ~rx_full : 1'b1;
  end
  assign rts = rts_q;

  // FIFO storage writes (contents need no reset)
  always_ff @(posedge clk) begin
    if (tx_push) txf_mem[txf_wp_q] <= bp.wdata[DATA_BITS-1:0];
    if (rx_push) rxf_mem[rxf_wp_q] <= rx_sh_q;
  end

  // FIFO pointers and occupancy counts
  always_ff @(posedge clk) begin
    if (!nReset) begin
      txf_wp_q <= '0; txf_rp_q <= '0; txf_cnt_q <= '0;
      rxf_wp_q <= '0; rxf_rp_q <= '0; rxf_cnt_q <= '0;
    end else begin
      if (tx_push) txf_wp_q <= txf_wp_q + AW'(1);
      if (tx_pop)  txf_rp_q <= txf_rp_q + AW'(1);
      txf_cnt_q <= txf_cnt_q + CW'(tx_push) - CW'(tx_pop);
      if (rx_push) rxf_wp_q <= rxf_wp_q + AW'(1);
      if (rx_pop)  rxf_rp_q <= rxf_rp_q + AW'(1);
      rxf_cnt_q <= rxf_cnt_q + CW'(rx_push) - CW'(rx_pop);
    end
  end

  // TX next-state: bit timer, shifter and frame sequencing
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tmr_d   = tx_tmr_q;
    tx_lat_d   = tx_lat_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    tx_bit_end = (tx_tmr_q == tx_lat_q);
    tx_go      = ctrl_q[0] & ~tx_empty & (~ctrl_q[2] | cts);
    // A new frame may start from IDLE or straight out of a finishing STOP.
    tx_load    = tx_go & ((tx_state_q == TX_IDLE) |
                          ((tx_state_q == TX_STOP) & tx_bit_end));
    tx_pop     = tx_load;
    if (tx_state_q != TX_IDLE) tx_tmr_d = tx_bit_end ? '0 : tx_tmr_q + DIV_W'(1);
    case (tx_state_q)
      TX_START: if (tx_bit_end) begin
        tx_state_d = TX_DATA;
        tx_bit_d   = '0;
      end
      TX_DATA: if (tx_bit_end) begin
        tx_sh_d = tx_sh_q >> 1;
        if (tx_bit_q == 3'(DATA_BITS - 1))
`ifdef UART_PARITY_EN
          tx_state_d = TX_PARITY;
`else
          tx_state_d = TX_STOP;
`endif
        else
          tx_bit_d = tx_bit_q + 3'd1;
      end
`ifdef UART_PARITY_EN
      TX_PARITY: if (tx_bit_end) tx_state_d = TX_STOP;
`endif
      TX_STOP: if (tx_bit_end) tx_state_d = TX_IDLE;
      default: ;
    endcase
    if (tx_load) begin
      tx_state_d = TX_START;
      tx_tmr_d   = '0;
      tx_lat_d   = div_q;
      tx_sh_d    = tx_head;
`ifdef UART_PARITY_EN
      tx_par_d   = ^tx_head ^ ctrl_q[3];
`endif
    end
    // Line level registered from the next state so tx is glitch-free.
    tx_d = 1'b1;
    if (tx_state_d == TX_START)     tx_d = 1'b0;
    else if (tx_state_d == TX_DATA) tx_d = tx_sh_d[0];
`ifdef UART_PARITY_EN
    else if (tx_state_d == TX_PARITY) tx_d = tx_par_d;
`endif
  end

  // TX state register
  always_ff @(posedge clk) begin
    if (!nReset) begin
      tx_state_q <= TX_IDLE;
      tx_tmr_q   <= '0;
      tx_lat_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_q       <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_tmr_q   <= tx_tmr_d;
      tx_lat_q   <= tx_lat_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_q       <= tx_d;
`ifdef UART_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end
  assign tx = tx_q;

  // RX input synchroniser plus one stage for falling-edge detection
  always_ff @(posedge clk) begin
    if (!nReset) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end
  assign rx_fall = rx_s3_q & ~rx_s2_q;

  // RX next-state: start validation at mid-bit, then one sample per bit
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_tmr_d    = rx_tmr_q;
    rx_lat_d    = rx_lat_q;
    rx_bit_d    = rx_bit_q;
    rx_sh_d     = rx_sh_q;
    rx_push_req = 1'b0;
    ferr_set    = 1'b0;
    perr_set    = 1'b0;
    rx_bit_end  = (rx_tmr_q == rx_lat_q);
    rx_mid      = (rx_tmr_q == (rx_lat_q >> 1));
    if (rx_state_q != RX_IDLE) rx_tmr_d = rx_tmr_q + DIV_W'(1);
    case (rx_state_q)
      RX_IDLE: if (ctrl_q[1] & rx_fall) begin
        rx_state_d = RX_START;
        rx_tmr_d   = '0;
        rx_lat_d   = div_q;
      end
      RX_START: if (rx_mid) begin
        if (rx_s2_q) rx_state_d = RX_IDLE;   // glitch, not a start bit
        else begin
          rx_state_d = RX_DATA;
          rx_tmr_d   = '0;
          rx_bit_d   = '0;
        end
      end
      RX_DATA: if (rx_bit_end) begin
        rx_tmr_d = '0;
        rx_sh_d  = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
        if (rx_bit_q == 3'(DATA_BITS - 1))
`ifdef UART_PARITY_EN
          rx_state_d = RX_PARITY;
`else
          rx_state_d = RX_STOP;
`endif
        else
          rx_bit_d = rx_bit_q + 3'd1;
      end
`ifdef UART_PARITY_EN
      RX_PARITY: if (rx_bit_end) begin
        rx_tmr_d   = '0;
        perr_set   = rx_s2_q ^ (^rx_sh_q ^ ctrl_q[3]);
        rx_state_d = RX_STOP;
      end
`endif
      RX_STOP: if (rx_bit_end) begin
        rx_state_d = RX_IDLE;
        if (!rx_s2_q) ferr_set    = 1'b1;
        else          rx_push_req = 1'b1;
      end
      default: ;
    endcase
  end

  // RX state register
  always_ff @(posedge clk) begin
    if (!nReset) begin
      rx_state_q <= RX_IDLE;
      rx_tmr_q   <= '0;
      rx_lat_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_tmr_q   <= rx_tmr_d;
      rx_lat_q   <= rx_lat_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_periph.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_fifo_periph
//  Purpose  : Directed self-checking bench for uart_fifo_periph (DIV=3, so
//             every bit lasts 4 clocks).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_fifo_periph;

`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nReset, rx_drv, loop_en, cts, tx, rts, rx_w;
  int   checks = 0;
  int   errors = 0;

  bus_protocol_if bp ();
  assign rx_w = loop_en ? tx : rx_drv;

  uart_fifo_periph #(
    .DATA_BITS(8), .FIFO_DEPTH(8), .DIV_W(16), .DEFAULT_DIV(867)
  ) dut (
    .clk(clk), .nReset(nReset), .rx(rx_w), .tx(tx),
    .cts(cts), .rts(rts), .bp(bp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // All steps start and end 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, output logic e);
    bp.addr = a; bp.wdata = d; bp.wen = 1'b1;
    @(negedge clk);
    e = bp.error;
    @(posedge clk); #1;
    bp.wen = 1'b0; bp.addr = '0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d, output logic e);
    bp.addr = a; bp.ren = 1'b1;
    @(negedge clk);
    d = bp.rdata; e = bp.error;
    @(posedge clk); #1;
    bp.ren = 1'b0; bp.addr = '0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx_drv = 1'b0; tick(4);
    for (int i = 0; i < 8; i++) begin rx_drv = b[i]; tick(4); end
`ifdef UART_PARITY_EN
    rx_drv = ^b; tick(4);
`endif
    rx_drv = stop; tick(4);
    rx_drv = 1'b1; tick(4);
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    logic [7:0]  b;
    logic        exp;
    int          idx;

    bp.wen = 1'b0; bp.ren = 1'b0; bp.addr = '0; bp.wdata = '0; bp.strobe = 4'hF;
    nReset = 1'b0; rx_drv = 1'b1; loop_en = 1'b0; cts = 1'b0;

    // Reset
    tick(3);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_rts", {31'd0, rts}, 32'd0);
    nReset = 1'b1;
    bus_rd(32'h4, d, e); chk("rst_stat", d, 32'h0A);
    chk("rst_rts_after", {31'd0, rts}, 32'd1);
    bus_rd(32'h8, d, e); chk("rst_div", d, 32'd867);
    bus_rd(32'hC, d, e); chk("rst_ctrl", d, 32'd0);

    // TX waveform of 0xA5
    bus_wr(32'h8, 32'd3, e);
    bus_wr(32'hC, 32'h1, e);
    b = 8'hA5;
    bus_wr(32'h0, {24'd0, b}, e); chk("tx_wr_err", {31'd0, e}, 32'd0);
    for (int c = 0; c < NB * 4 + 4; c++) begin
      tick(1);
      idx = c / 4;
      if (idx == 0)      exp = 1'b0;
      else if (idx <= 8) exp = b[idx-1];
`ifdef UART_PARITY_EN
      else if (idx == 9) exp = ^b;
`endif
      else               exp = 1'b1;
      chk($sformatf("tx_bit_c%0d", c), {31'd0, tx}, {31'd0, exp});
    end
    bus_rd(32'h4, d, e); chk("tx_stat", d, 32'h0A);

    // Loopback
    loop_en = 1'b1;
    bus_wr(32'hC, 32'h3, e);
    bus_wr(32'h0, 32'h3C, e);
    bus_wr(32'h0, 32'h81, e);
    tick(120);
    bus_rd(32'h4, d, e); chk("lb_stat", d, 32'h02);
    bus_rd(32'h0, d, e); chk("lb_rd0", d, 32'h3C); chk("lb_rd0_err", {31'd0, e}, 32'd0);
    bus_rd(32'h0, d, e); chk("lb_rd1", d, 32'h81);
    bus_rd(32'h0, d, e); chk("lb_rd2", d, 32'h0);  chk("lb_rd2_err", {31'd0, e}, 32'd1);
    loop_en = 1'b0;

    // Overrun
    bus_wr(32'hC, 32'h2, e);
    for (int i = 0; i < 9; i++) send_frame(8'h10 + 8'(i), 1'b1);
    bus_rd(32'h4, d, e); chk("ovr_stat", d, 32'h16);
    bus_rd(32'h4, d, e); chk("ovr_clr", d, 32'h06);
    for (int i = 0; i < 8; i++) begin
      bus_rd(32'h0, d, e); chk($sformatf("ovr_rd%0d", i), d, 32'h10 + i);
    end
    bus_rd(32'h0, d, e); chk("ovr_lost_err", {31'd0, e}, 32'd1);

    // Flow control
    bus_wr(32'hC, 32'h5, e);
    bus_wr(32'h0, 32'h55, e);
    for (int i = 0; i < 8; i++) begin
      tick(1); chk($sformatf("fc_hold%0d", i), {31'd0, tx}, 32'd1);
    end
    cts = 1'b1;
    tick(1); chk("fc_start", {31'd0, tx}, 32'd0);
    tick(50);
    chk("fc_rts_space", {31'd0, rts}, 32'd1);
    bus_wr(32'hC, 32'h6, e);
    for (int i = 0; i < 8; i++) send_frame(8'h20 + 8'(i), 1'b1);
    tick(2);
    chk("fc_rts_full", {31'd0, rts}, 32'd0);
    bus_rd(32'h4, d, e); chk("fc_stat", d, 32'h06);
    for (int i = 0; i < 8; i++) begin
      bus_rd(32'h0, d, e); chk($sformatf("fc_rd%0d", i), d, 32'h20 + i);
    end
    tick(2);
    chk("fc_rts_free", {31'd0, rts}, 32'd1);

    // Framing error, bad address
    bus_wr(32'hC, 32'h2, e);
    send_frame(8'h5A, 1'b0);
    bus_rd(32'h4, d, e); chk("ferr_stat", d, 32'h2A);
    bus_rd(32'h4, d, e); chk("ferr_clr", d, 32'h0A);
    bus_rd(32'h0, d, e); chk("ferr_nopush", {31'd0, e}, 32'd1);
    bus_wr(32'h10, 32'hFF, e); chk("badaddr_wr", {31'd0, e}, 32'd1);
    bus_rd(32'h10, d, e); chk("badaddr_rd_err", {31'd0, e}, 32'd1); chk("badaddr_rd", d, 32'd0);
    bus_rd(32'hC, d, e); chk("badaddr_noeff", d, 32'h2);

    // TX FIFO full
    bus_wr(32'hC, 32'h0, e);
    for (int i = 0; i < 8; i++) begin
      bus_wr(32'h0, 32'h30 + i, e); chk($sformatf("full_wr%0d", i), {31'd0, e}, 32'd0);
    end
    bus_wr(32'h0, 32'hEE, e); chk("full_wr_err", {31'd0, e}, 32'd1);
    bus_rd(32'h4, d, e); chk("full_stat", d, 32'h09);
    bus_wr(32'hC, 32'h1, e);
    tick(270);
    bus_rd(32'h4, d, e); chk("full_drain_mid", d, 32'h08);
    tick(20);
    bus_rd(32'h4, d, e); chk("full_drain_end", d, 32'h0A);
    tick(40);

    // Reset mid-frame
    bus_wr(32'h0, 32'h00, e);
    tick(10);
    chk("mid_tx_low", {31'd0, tx}, 32'd0);
    nReset = 1'b0;
    tick(1);
    chk("mid_rst_tx", {31'd0, tx}, 32'd1);
    nReset = 1'b1;
    tick(1);
    bus_rd(32'h4, d, e); chk("mid_rst_stat", d, 32'h0A);
    bus_rd(32'hC, d, e); chk("mid_rst_ctrl", d, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
